lab7_mem_ctrl: RTL

LAB7_MEM_CTRL -- requirements
Module: lab7_mem_ctrl

---
 rtl/lab7_pkg.sv | 45 ++++
 rtl/lab7_mem_ctrl_sync2.sv | 24 ++
 rtl/lab7_mem_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/lab7_pkg.sv
// Shared definitions for the lab 7 memory controller: CPU command codes,
// the two I/O addresses, FSM state encoding and the address/command decoder.
package lab7_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_RAM_WR = 3'd0,
        OP_RAM_RD = 3'd1,
        OP_LED_WR = 3'd2,
        OP_SW_RD  = 3'd3,
        OP_ERR    = 3'd4
    } op_t;

    // Anything not explicitly legal (MNONE, cmd 11, unmapped address,
    // wrong direction on an I/O port) falls through to OP_ERR.
    function automatic op_t classify(input logic [1:0] cmd, input logic [8:0] addr);
        op_t op;
        op = OP_ERR;
        if (!addr[8]) begin
            if (cmd == MWRITE)
                op = OP_RAM_WR;
            else if (cmd == MREAD)
                op = OP_RAM_RD;
        end else if (addr == LED_ADDR && cmd == MWRITE) begin
            op = OP_LED_WR;
        end else if (addr == SW_ADDR && cmd == MREAD) begin
            op = OP_SW_RD;
        end
        return op;
    endfunction

endpackage

// File: rtl/lab7_mem_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous level inputs such as board switches.
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Shift the raw input through two stages every cycle to settle metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lab7_mem_ctrl.sv
// CPU-side memory controller: decodes each request to the RAM, the LED
// register or the switch port, and returns a one-cycle ready pulse.
// RAM address/data come straight from the capture registers so they stay
// stable for the whole transaction.
module lab7_mem_ctrl
    import lab7_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        ready,
    output logic        bus_err,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  SW,
    output logic [7:0]  LEDR
);

    state_t      state;
    logic [1:0]  cmd_q;
    logic [8:0]  addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  sw_sync;
    op_t         op;

    sync2 #(.WIDTH(8)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (SW),
        .q     (sw_sync)
    );

    assign op       = classify(cmd_q, addr_q);
    assign ram_addr = addr_q[7:0];
    assign ram_din  = wdata_q;

    // Transaction FSM; ready and ram_we are registered one state ahead so they
    // are high exactly while the FSM sits in DONE / DECODE respectively.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= MNONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
            ready     <= 1'b0;
            bus_err   <= 1'b0;
            ram_we    <= 1'b0;
            LEDR      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready  <= 1'b0;
                    ram_we <= 1'b0;
                    if (req) begin
                        cmd_q   <= mem_cmd;
                        addr_q  <= mem_addr;
                        wdata_q <= write_data;
                        bus_err <= 1'b0;
                        ram_we  <= (classify(mem_cmd, mem_addr) == OP_RAM_WR);
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    ram_we <= 1'b0;
                    case (op)
                        OP_RAM_WR: begin
                            ready <= 1'b1;
                            state <= DONE;
                        end
                        OP_RAM_RD: begin
                            state <= RD_WAIT;
                        end
                        OP_LED_WR: begin
                            LEDR  <= wdata_q[7:0];
                            ready <= 1'b1;
                            state <= DONE;
                        end
                        OP_SW_RD: begin
                            read_data <= {8'h00, sw_sync};
                            ready     <= 1'b1;
                            state     <= DONE;
                        end
                        default: begin
                            bus_err <= 1'b1;
                            ready   <= 1'b1;
                            state   <= DONE;
                        end
                    endcase
                end
                RD_WAIT: begin
                    read_data <= ram_dout;
                    ready     <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready  <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
